// File: rtl/composite_timing_gen.sv
// Composite-video timing generator: free-running line/pixel counters, sync/active decode,
// pixel fetch strobes and a registered luminance output. Define INTERLACE_EN for alternating field lengths.
module composite_timing_gen #(
  parameter int H_TOTAL        = 2032,
  parameter int H_SYNC         = 150,
  parameter int H_ACTIVE_START = 512,
  parameter int H_ACTIVE_END   = 1792,
  parameter int V_TOTAL        = 262,
  parameter int V_SYNC         = 3,
  parameter int V_ACTIVE_START = 32,
  parameter int V_ACTIVE_END   = 232,
  parameter int PIX_DIV        = 4,
  localparam int H_PIXELS = (H_ACTIVE_END - H_ACTIVE_START) / PIX_DIV,
  localparam int V_LINES  = V_ACTIVE_END - V_ACTIVE_START,
  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1,
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pixel_data,
  output logic          sync,
  output logic          active,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          pixel_strobe,
  output logic          line_start,
  output logic          frame_start,
  output logic          luminance,
  output logic          field
);

  localparam int HW  = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW  = $clog2(V_TOTAL + 1);
  localparam int PSH = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 0;

  // Horizontal limits compared one bit wider so H_ACTIVE_END == H_TOTAL cannot alias to 0.
  localparam logic [HW:0]   H_SYNC_X  = (HW+1)'(H_SYNC);
  localparam logic [HW:0]   H_AS_X    = (HW+1)'(H_ACTIVE_START);
  localparam logic [HW:0]   H_AE_X    = (HW+1)'(H_ACTIVE_END);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_AS      = HW'(H_ACTIVE_START);
  localparam logic [HW-1:0] PIX_MASK  = HW'(PIX_DIV - 1);
  localparam logic [VW-1:0] V_SYNC_C  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_AS      = VW'(V_ACTIVE_START);
  localparam logic [VW-1:0] V_AE      = VW'(V_ACTIVE_END);
  localparam logic [VW-1:0] V_LAST_EV = VW'(V_TOTAL - 1);

  if (!(H_SYNC < H_ACTIVE_START && H_ACTIVE_START < H_ACTIVE_END && H_ACTIVE_END <= H_TOTAL))
  begin : g_bad_h
    $error("composite_timing_gen: horizontal timing parameters out of order");
  end
  if (!(V_SYNC < V_ACTIVE_START && V_ACTIVE_START < V_ACTIVE_END && V_ACTIVE_END <= V_TOTAL))
  begin : g_bad_v
    $error("composite_timing_gen: vertical timing parameters out of order");
  end
  if (PIX_DIV < 1 || (PIX_DIV & (PIX_DIV - 1)) != 0 ||
      ((H_ACTIVE_END - H_ACTIVE_START) % PIX_DIV) != 0)
  begin : g_bad_pix
    $error("composite_timing_gen: PIX_DIV must be a power of two dividing the active width");
  end

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          luminance_q, luminance_d;
  logic          h_last, v_last;
  logic [HW:0]   hc_x;
  logic [HW-1:0] hoff;
  logic [VW-1:0] voff;
  logic          hsync, vsync, h_act, v_act, phase0;

  assign h_last = (hcount_q == H_LAST);

`ifdef INTERLACE_EN
  logic field_q, field_d;

  // Odd fields carry one extra, never-active line at vcount == V_TOTAL.
  assign v_last  = field_q ? (vcount_q == VW'(V_TOTAL)) : (vcount_q == V_LAST_EV);
  assign field_d = field_q ^ (h_last & v_last);
  assign field   = field_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) field_q <= 1'b0;
    else       field_q <= field_d;
  end
`else
  assign v_last = (vcount_q == V_LAST_EV);
  assign field  = 1'b0;
`endif

  always_comb begin
    hcount_d = h_last ? '0 : hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (h_last) vcount_d = v_last ? '0 : vcount_q + VW'(1);
  end

  assign hc_x   = {1'b0, hcount_q};
  assign hoff   = hcount_q - H_AS;
  assign voff   = vcount_q - V_AS;
  assign hsync  = (hc_x < H_SYNC_X);
  assign vsync  = (vcount_q < V_SYNC_C);
  assign h_act  = (hc_x >= H_AS_X) && (hc_x < H_AE_X);
  assign v_act  = (vcount_q >= V_AS) && (vcount_q < V_AE);
  assign phase0 = ((hoff & PIX_MASK) == '0);

  assign sync    = ~(hsync ^ vsync);
  assign active  = h_act & v_act;
  assign pixel_x = active ? XW'(hoff >> PSH) : '0;
  assign pixel_y = active ? YW'(voff) : '0;

  // Strobes are single-cycle, fire-and-forget: there is no ready back-pressure, the fetcher
  // must present pixel_data for (pixel_x, pixel_y) in the same cycle pixel_strobe is high.
  assign pixel_strobe = active & phase0 & ~reset;
  assign line_start   = (hcount_q == '0) & ~reset;
  assign frame_start  = (hcount_q == '0) & (vcount_q == '0) & ~reset;

  always_comb begin
    luminance_d = luminance_q;
    if (active & phase0) luminance_d = pixel_data;
    else if (!active)    luminance_d = 1'b0;
  end

  assign luminance = luminance_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      luminance_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      luminance_q <= luminance_d;
    end
  end

endmodule

// File: tb/tb_composite_timing_gen.sv
// Bench for composite_timing_gen with reduced timing: cycle-indexed reference model feeding an
// expected queue, checked by a negedge monitor. Define INTERLACE_EN to match an interlaced build.
module tb_composite_timing_gen;

  localparam int HT  = 40;
  localparam int HS  = 4;
  localparam int HAS = 8;
  localparam int HAE = 32;
  localparam int VT  = 12;
  localparam int VS  = 2;
  localparam int VAS = 3;
  localparam int VAE = 10;
  localparam int PD  = 4;
  localparam int XW  = $clog2((HAE - HAS) / PD);
  localparam int YW  = $clog2(VAE - VAS);
  localparam int W   = 7 + XW + YW;
  localparam int FR  = HT * VT;

  logic          clock = 1'b0;
  logic          reset;
  logic          pixel_data;
  logic          sync, active, pixel_strobe, line_start, frame_start, luminance, field;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;

  composite_timing_gen #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACTIVE_START(HAS), .H_ACTIVE_END(HAE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACTIVE_START(VAS), .V_ACTIVE_END(VAE), .PIX_DIV(PD)
  ) dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data),
    .sync(sync), .active(active), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_strobe(pixel_strobe), .line_start(line_start), .frame_start(frame_start),
    .luminance(luminance), .field(field)
  );

  // clock / reset
  always #5 clock = ~clock;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic mon_en = 1'b0;

  // reference model state: t counts cycles since reset release
  int   t = 0;
  logic rst_prev = 1'b1;
  logic lum_m = 1'b0;
  logic stb_p = 1'b0, act_p = 1'b0, pd_p = 1'b0;
  int   cur_h = 0, cur_v = 0;

  function automatic void timing_at(input int tt, output int h, output int v, output int f);
    int line;
    line = tt / HT;
    h = tt % HT;
`ifdef INTERLACE_EN
    if ((line % (2 * VT + 1)) < VT) begin
      v = line % (2 * VT + 1);
      f = 0;
    end else begin
      v = (line % (2 * VT + 1)) - VT;
      f = 1;
    end
`else
    v = line % VT;
    f = 0;
`endif
  endfunction

  // driver: mode 0 random pixel data, mode 1 pixel_data=1 only for pixel_x==2
  task step(input logic rst_v, input int mode);
    int h, v, f, px, py;
    logic hs_e, vs_e, act_e, stb_e, ls_e, fs_e, pd;
    @(posedge clock);
    if (!rst_prev) begin
      lum_m = stb_p ? pd_p : (act_p ? lum_m : 1'b0);
      t++;
    end
    #1;
    reset = rst_v;
    if (rst_v) begin
      t = 0;
      lum_m = 1'b0;
    end
    timing_at(t, h, v, f);
    cur_h = h;
    cur_v = v;
    hs_e  = (h < HS);
    vs_e  = (v < VS);
    act_e = (h >= HAS) && (h < HAE) && (v >= VAS) && (v < VAE);
    px    = act_e ? (h - HAS) / PD : 0;
    py    = act_e ? (v - VAS) : 0;
    stb_e = act_e && ((h - HAS) % PD == 0) && !rst_v;
    ls_e  = (h == 0) && !rst_v;
    fs_e  = (h == 0) && (v == 0) && !rst_v;
    pd    = (mode == 1) ? (act_e && px == 2) : 1'($urandom_range(0, 1));
    pixel_data = pd;
    exp_q.push_back({~(hs_e ^ vs_e), act_e, XW'(px), YW'(py), stb_e, ls_e, fs_e, lum_m, f[0]});
    mon_en   = 1'b1;
    stb_p    = stb_e;
    act_p    = act_e;
    pd_p     = pd;
    rst_prev = rst_v;
  endtask

  // scoreboard monitor
  int   mon_cyc = 0, last_fs_cyc = 0;
  logic have_fs = 1'b0, last_fld = 1'b0;
  logic [W-1:0] e, got;

  always @(negedge clock) begin
    if (mon_en) begin
      mon_cyc++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL queue_empty cycle %0d: no expected entry for DUT output", mon_cyc);
      end else begin
        e   = exp_q.pop_front();
        got = {sync, active, pixel_x, pixel_y, pixel_strobe, line_start, frame_start,
               luminance, field};
        if (got !== e) begin
          n_fail++;
          $display("FAIL outputs cycle %0d: got {sync,act,x,y,stb,ls,fs,lum,fld}=%b expected %b",
                   mon_cyc, got, e);
        end
        if (reset) begin
          have_fs = 1'b0;
        end else if (frame_start === 1'b1) begin
          if (have_fs) begin
            n_tests++;
            if (mon_cyc - last_fs_cyc != HT * (last_fld ? VT + 1 : VT)) begin
              n_fail++;
              $display("FAIL frame_period: got %0d clocks, expected %0d", mon_cyc - last_fs_cyc,
                       HT * (last_fld ? VT + 1 : VT));
            end
          end
          have_fs     = 1'b1;
          last_fs_cyc = mon_cyc;
          last_fld    = e[0];
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    pixel_data = 1'b0;
    for (int i = 0; i < 10; i++) step(1'b1, 0);
    for (int i = 0; i < 3 * FR; i++) step(1'b0, 0);
    for (int i = 0; i < 2 * FR + HT; i++) step(1'b0, 1);
    for (int i = 0; i < 3 * FR && !(cur_v == 5 && cur_h == 20); i++) step(1'b0, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 0);
    for (int i = 0; i < 3 * FR; i++) step(1'b0, 0);
    @(negedge clock);
    #1;
    mon_en = 1'b0;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
